arranque_rampa_multi: RTL

ARRANQUE_RAMPA_MULTI -- requirements
Module: arranque_rampa_multi

---
 rtl/arranque_rampa_multi.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/arranque_rampa_multi.sv
// ============================================================================
// Module   : arranque_rampa_multi
// Brief    : Multi-stage ramp starter. Steps a thermometer stage indicator up
//            (and, with RAMP_DOWN_EN defined, back down) at a mode-selected pace.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arranque_rampa_multi #(
    parameter int NSTAGES    = 3,
    parameter int CLK_DIV    = 100000000,
    parameter int DWELL_FAST = 1,
    parameter int DWELL_SLOW = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               rapido,
    input  logic               lento,
    input  logic               fault,
    output logic [NSTAGES-1:0] stage_out,
    output logic               at_speed,
    output logic               busy,
    output logic               err
);

    localparam int c_PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_DMAX = (DWELL_SLOW > DWELL_FAST) ? DWELL_SLOW : DWELL_FAST;
    localparam int c_DW   = (c_DMAX > 1) ? $clog2(c_DMAX) : 1;
    localparam int c_SW   = $clog2(NSTAGES + 1);

    localparam logic [c_PW-1:0] c_PRESC_LAST      = c_PW'(CLK_DIV - 1);
    localparam logic [c_DW-1:0] c_DWELL_FAST_LAST = c_DW'(DWELL_FAST - 1);
    localparam logic [c_DW-1:0] c_DWELL_SLOW_LAST = c_DW'(DWELL_SLOW - 1);
    localparam logic [c_SW-1:0] c_STAGE_PRE_TOP   = c_SW'(NSTAGES - 1);
`ifdef RAMP_DOWN_EN
    localparam logic [c_SW-1:0] c_STAGE_TOP       = c_SW'(NSTAGES);
    localparam logic [c_SW-1:0] c_STAGE_ONE       = c_SW'(1);
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP_UP   = 3'd1,
        ST_RUN       = 3'd2,
        ST_RAMP_DOWN = 3'd3,
        ST_FAULT     = 3'd4
    } state_t;

    state_t          r_state, w_state_next;
    logic [c_SW-1:0] r_stage, w_stage_next;
    logic [c_PW-1:0] r_presc, w_presc_next;
    logic [c_DW-1:0] r_dwell, w_dwell_next;
    logic            r_mode_slow, w_mode_next;
    logic            w_tick;
    logic [c_DW-1:0] w_dwell_last;

    assign w_tick       = (r_presc == c_PRESC_LAST);
    assign w_dwell_last = r_mode_slow ? c_DWELL_SLOW_LAST : c_DWELL_FAST_LAST;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_stage     <= '0;
            r_presc     <= '0;
            r_dwell     <= '0;
            r_mode_slow <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_stage     <= w_stage_next;
            r_presc     <= w_presc_next;
            r_dwell     <= w_dwell_next;
            r_mode_slow <= w_mode_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_stage_next = r_stage;
        w_presc_next = r_presc;
        w_dwell_next = r_dwell;
        w_mode_next  = r_mode_slow;

        case (r_state)
            ST_IDLE: begin
                w_stage_next = '0;
                w_presc_next = '0;
                w_dwell_next = '0;
                // lento wins over rapido; neither selected means the start is refused
                if (run && (lento || rapido)) begin
                    w_mode_next  = lento;
                    w_state_next = ST_RAMP_UP;
                    w_stage_next = c_SW'(1);
                end
            end

            ST_RAMP_UP: begin
                if (!run) begin
                    w_presc_next = '0;
                    w_dwell_next = '0;
`ifdef RAMP_DOWN_EN
                    w_state_next = ST_RAMP_DOWN;
`else
                    w_state_next = ST_IDLE;
                    w_stage_next = '0;
`endif
                end else if (w_tick) begin
                    w_presc_next = '0;
                    if (r_dwell == w_dwell_last) begin
                        w_dwell_next = '0;
                        w_stage_next = r_stage + 1'b1;
                        if (r_stage == c_STAGE_PRE_TOP) begin
                            w_state_next = ST_RUN;
                        end
                    end else begin
                        w_dwell_next = r_dwell + 1'b1;
                    end
                end else begin
                    w_presc_next = r_presc + 1'b1;
                end
            end

            ST_RUN: begin
                w_presc_next = '0;
                w_dwell_next = '0;
                if (!run) begin
`ifdef RAMP_DOWN_EN
                    w_state_next = ST_RAMP_DOWN;
`else
                    w_state_next = ST_IDLE;
                    w_stage_next = '0;
`endif
                end
            end

`ifdef RAMP_DOWN_EN
            ST_RAMP_DOWN: begin
                if (run) begin
                    // resume upward from the current stage, keeping the latched pace
                    w_presc_next = '0;
                    w_dwell_next = '0;
                    w_state_next = (r_stage == c_STAGE_TOP) ? ST_RUN : ST_RAMP_UP;
                end else if (w_tick) begin
                    w_presc_next = '0;
                    if (r_dwell == w_dwell_last) begin
                        w_dwell_next = '0;
                        w_stage_next = r_stage - 1'b1;
                        if (r_stage == c_STAGE_ONE) begin
                            w_state_next = ST_IDLE;
                        end
                    end else begin
                        w_dwell_next = r_dwell + 1'b1;
                    end
                end else begin
                    w_presc_next = r_presc + 1'b1;
                end
            end
`endif

            ST_FAULT: begin
                w_stage_next = '0;
                w_presc_next = '0;
                w_dwell_next = '0;
                if (!run) begin
                    w_state_next = ST_IDLE;
                end
            end

            default: begin
                w_state_next = ST_IDLE;
                w_stage_next = '0;
                w_presc_next = '0;
                w_dwell_next = '0;
            end
        endcase

        // abort overrides every transition above
        if (fault) begin
            w_state_next = ST_FAULT;
            w_stage_next = '0;
            w_presc_next = '0;
            w_dwell_next = '0;
        end
    end

    generate
        for (genvar i = 0; i < NSTAGES; i++) begin : g_therm
            assign stage_out[i] = (r_stage > c_SW'(i));
        end
    endgenerate

    assign at_speed = (r_state == ST_RUN);
    assign busy     = (r_state == ST_RAMP_UP) || (r_state == ST_RAMP_DOWN);
    assign err      = (r_state == ST_FAULT);

endmodule

`default_nettype wire
